// File: rtl/wbl_load_ctrl_pkg.sv
// Shared definitions for the WBL key-load controller: FSM encoding and sizing defaults.
package wbl_load_ctrl_pkg;

  localparam int unsigned RowsDefault  = 64;
  localparam int unsigned AddrWDefault = 6;
  localparam int unsigned KeyW         = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/wbl_load_ctrl.sv
// Sweeps WBL row addresses for wbl_key_gen and hands each row to the array.
// Optional macro WBL_ROW_RANGE_EN adds row_first/row_last to limit the sweep.
module wbl_load_ctrl
  import wbl_load_ctrl_pkg::*;
#(
  parameter int unsigned ROWS   = RowsDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [KeyW-1:0]   key_in,
  input  logic              wr_ready,
`ifdef WBL_ROW_RANGE_EN
  input  logic [ADDR_W-1:0] row_first,
  input  logic [ADDR_W-1:0] row_last,
`endif
  output logic [KeyW-1:0]   gen_key,
  output logic [ADDR_W-1:0] gen_addr,
  output logic              wr_valid,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [KeyW-1:0]   key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] first_w, last_w;

`ifdef WBL_ROW_RANGE_EN
  assign first_w = row_first;
  assign last_w  = row_last;
`else
  assign first_w = '0;
  assign last_w  = ADDR_W'(ROWS - 1);
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        // start wins over abort here; abort has nothing to cancel in idle
        if (start) begin
          key_d   = key_in;
          addr_d  = first_w;
          last_d  = last_w;
          state_d = (first_w > last_w) ? StDone : StWrite;
        end
      end
      StWrite: begin
        if (abort) begin
          state_d = StIdle;
        end else if (wr_ready) begin
          if (addr_q == last_q) begin
            state_d = StDone;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign gen_key  = key_q;
  assign gen_addr = addr_q;
  assign wr_valid = (state_q == StWrite);
  assign busy     = (state_q != StIdle);
  // An abort landing on the done cycle suppresses the pulse
  assign done     = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_wbl_load_ctrl.sv
// Directed bench for wbl_load_ctrl with an expected-row scoreboard.
module tb_wbl_load_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [127:0] key_in;
  logic         wr_ready;
  logic [127:0] gen_key;
  logic [5:0]   gen_addr;
  logic         wr_valid;
  logic         busy;
  logic         done;
`ifdef WBL_ROW_RANGE_EN
  logic [5:0]   row_first;
  logic [5:0]   row_last;
`endif

  wbl_load_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .key_in   (key_in),
    .wr_ready (wr_ready),
`ifdef WBL_ROW_RANGE_EN
    .row_first(row_first),
    .row_last (row_last),
`endif
    .gen_key  (gen_key),
    .gen_addr (gen_addr),
    .wr_valid (wr_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [5:0]   sb[$];
  logic [127:0] exp_key;
  int           exp_first = 0;
  int           exp_last  = 63;
  int           nvalid, ntr, ndone, done_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a post-edge sample point with the DUT idle.
  task automatic do_start(input logic [127:0] key, input logic with_abort);
    start   = 1'b1;
    abort   = with_abort;
    key_in  = key;
    exp_key = key;
    sb.delete();
    for (int r = exp_first; r <= exp_last; r++) sb.push_back(6'(r));
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run(input logic rnd, input int abort_at, input int rst_at,
                     input logic disturb);
    logic finished;
    logic [5:0] e;
    finished = 1'b0;
    nvalid = 0; ntr = 0; ndone = 0; done_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c + 1;
      end
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort    = (abort_at >= 0) && wr_valid && (int'(gen_addr) == abort_at);
      if (disturb) begin
        start  = (c == 10);
        key_in = (c >= 10) ? ~exp_key : exp_key;
      end
      if (rst_at >= 0 && wr_valid && int'(gen_addr) == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gen_addr", 128'(gen_addr), 0);
        chk("rst_gen_key", gen_key, 0);
        chk("rst_wr_valid", 128'(wr_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        finished = 1'b1;
        break;
      end
      #1;
      if (wr_valid) begin
        nvalid++;
        if (wr_ready && !abort) begin
          ntr++;
          chk("sb_nonempty", 128'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("xfer_addr", 128'(gen_addr), 128'(e));
          end
          chk("xfer_key", gen_key, exp_key);
        end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    chk("run_terminated", 128'(finished), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_in = '0; wr_ready = 1'b0;
`ifdef WBL_ROW_RANGE_EN
    row_first = 6'd0; row_last = 6'd63;
`endif
    #12;
    chk("reset_busy", 128'(busy), 0);
    chk("reset_valid", 128'(wr_valid), 0);
    chk("reset_done", 128'(done), 0);
    chk("reset_addr", 128'(gen_addr), 0);
    chk("reset_key", gen_key, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full sweep, key zero, ready tied high
    do_start('0, 1'b0);
    chk("first_valid", 128'(wr_valid), 1);
    run(1'b0, -1, -1, 1'b0);
    chk("full_valid_cycles", 128'(nvalid), 64);
    chk("full_xfers", 128'(ntr), 64);
    chk("full_done_count", 128'(ndone), 1);
    chk("full_done_cycle", 128'(done_cyc), 65);
    chk("full_sb_drained", 128'(sb.size()), 0);

    // Random backpressure with a nonzero key
    do_start(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0);
    run(1'b1, -1, -1, 1'b0);
    chk("rnd_xfers", 128'(ntr), 64);
    chk("rnd_done_count", 128'(ndone), 1);
    chk("rnd_sb_drained", 128'(sb.size()), 0);
    chk("rnd_valid_ge_xfers", 128'(nvalid >= 64), 1);

    // Abort at row 20
    do_start(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 1'b0);
    run(1'b0, 20, -1, 1'b0);
    chk("abort_no_done", 128'(ndone), 0);
    chk("abort_remaining", 128'(sb.size()), 44);
    chk("abort_idle", 128'(busy), 0);
    do_start(128'hfeed_face, 1'b0);
    chk("restart_addr", 128'(gen_addr), 0);
    run(1'b0, -1, -1, 1'b0);
    chk("restart_done", 128'(ndone), 1);
    chk("restart_drained", 128'(sb.size()), 0);

    // Abort coinciding with the final transfer
    do_start(128'h55, 1'b0);
    run(1'b0, 63, -1, 1'b0);
    chk("abort_last_no_done", 128'(ndone), 0);
    chk("abort_last_remaining", 128'(sb.size()), 1);

    // start pulse and key change during a load
    do_start(128'hcafe_0000_beef, 1'b0);
    run(1'b1, -1, -1, 1'b1);
    chk("disturb_xfers", 128'(ntr), 64);
    chk("disturb_done", 128'(ndone), 1);
    chk("disturb_drained", 128'(sb.size()), 0);

    // start and abort together in idle: start wins
    do_start(128'h77, 1'b1);
    chk("start_beats_abort", 128'(busy), 1);
    run(1'b0, -1, -1, 1'b0);
    chk("sba_done", 128'(ndone), 1);

    // Asynchronous reset at row 40, then a clean restart
    do_start(128'habcd, 1'b0);
    run(1'b0, -1, 40, 1'b0);
    do_start(128'h1234, 1'b0);
    chk("post_rst_addr", 128'(gen_addr), 0);
    run(1'b0, -1, -1, 1'b0);
    chk("post_rst_done", 128'(ndone), 1);
    chk("post_rst_drained", 128'(sb.size()), 0);

`ifdef WBL_ROW_RANGE_EN
    exp_first = 5; exp_last = 9;
    row_first = 6'd5; row_last = 6'd9;
    do_start(128'h99, 1'b0);
    run(1'b0, -1, -1, 1'b0);
    chk("range_xfers", 128'(ntr), 5);
    chk("range_done", 128'(ndone), 1);
    chk("range_drained", 128'(sb.size()), 0);
    exp_first = 9; exp_last = 5;
    row_first = 6'd9; row_last = 6'd5;
    do_start(128'h98, 1'b0);
    chk("empty_range_done", 128'(done), 1);
    run(1'b0, -1, -1, 1'b0);
    chk("empty_range_valid", 128'(nvalid), 0);
    chk("empty_range_done_cyc", 128'(done_cyc), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wbl_load_ctrl.md
WBL_LOAD_CTRL -- requirements
Module: wbl_load_ctrl

Interface
REQ-001 Parameter ROWS, default 64, number of WBL address rows swept per load (power of two, max 64).
REQ-002 Parameter ADDR_W, default 6, width of row address, equals log2(ROWS).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to load a new key; sampled only in IDLE.
REQ-006 abort  input  1  cancel an in-progress load.
REQ-007 key_in  input  128  AES-128 key, captured on accepted start.
REQ-008 wr_ready  input  1  array accepts the current 16-word WBL row this cycle.
REQ-009 gen_key  output  128  latched key, drives Kin of wbl_key_gen.
REQ-010 gen_addr  output  ADDR_W  row address, drives addr of wbl_key_gen.
REQ-011 wr_valid  output  1  WBL1..WBL16 at gen_addr are valid for the array to write.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after final row is accepted.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, DONE.
REQ-015 IDLE: start=1 SHALL latch key_in into gen_key, set gen_addr to first row, go to WRITE next cycle.
REQ-016 wr_valid SHALL be high exactly when state is WRITE; first wr_valid is one cycle after accepted start.
REQ-017 A row transfer SHALL occur on a cycle with wr_valid and wr_ready both high.
REQ-018 On transfer with gen_addr != last row, gen_addr SHALL increment by 1 next cycle; state stays WRITE.
REQ-019 On transfer with gen_addr == last row, state SHALL go to DONE; gen_addr holds.
REQ-020 wr_ready low SHALL hold gen_addr, gen_key and wr_valid unchanged (no row skipped or repeated).
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 gen_key SHALL be stable for the whole load; key_in changes after start SHALL have no effect.
REQ-023 start while busy SHALL be ignored, not queued.
REQ-024 abort in WRITE or DONE SHALL force IDLE next cycle, no done pulse; abort beats a simultaneous final transfer.
REQ-025 abort and start together in IDLE: start SHALL win (abort is a no-op in IDLE).
REQ-026 With wr_ready tied high, a full load SHALL take ROWS cycles of wr_valid plus one DONE cycle.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, gen_key=0, gen_addr=0, wr_valid=0, busy=0, done=0.
REQ-028 Reset mid-load SHALL discard progress; the next start restarts from the first row.

Configuration
REQ-029 Macro WBL_ROW_RANGE_EN SHALL add inputs row_first and row_last (ADDR_W each), captured on accepted start.
REQ-030 With WBL_ROW_RANGE_EN: sweep SHALL run row_first..row_last inclusive; row_first > row_last SHALL go straight to DONE with no wr_valid.
REQ-031 Without WBL_ROW_RANGE_EN: ports absent; sweep SHALL run 0..ROWS-1.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding and the ROWS/ADDR_W defaults.
REQ-033 wbl_key_gen SHALL be instantiated outside this block; wbl_load_ctrl SHALL contain no sub-modules.

Verification
REQ-034 Reset, start=1 key=0, wr_ready=1 -> gen_addr 0..63 on consecutive cycles, done at cycle 65, array contents match wbl_key_gen golden rows.
REQ-035 wr_ready toggled 1-0-1 pseudo-randomly -> exactly 64 transfers, addresses strictly 0..63 in order, one done.
REQ-036 abort asserted at gen_addr=20 -> IDLE next cycle, no done, next start begins at row 0.
REQ-037 start pulsed during WRITE and key_in changed -> gen_key unchanged, no restart.
REQ-038 rst_n low at gen_addr=40 -> outputs zero asynchronously, busy=0 before next edge.
REQ-039 WBL_ROW_RANGE_EN, first=5 last=9 -> 5 transfers rows 5..9 then done; first=9 last=5 -> done one cycle after start, no wr_valid.
